imem_read_arbiter: RTL



---
 rtl/imem_read_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/imem_read_arbiter.sv
// Two-port round-robin arbiter in front of a synchronous instruction ROM.
// One word read outstanding at a time; misaligned requests get an error response.
module imem_read_arbiter #(
    parameter int ADDR_DEPTH = 14
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  F_REQ,
    input  logic [ADDR_DEPTH+1:0] F_ADDR,
    output logic                  F_GNT,
    output logic                  F_RVALID,
    output logic [31:0]           F_RDATA,
    output logic                  F_RERR,
    input  logic                  F_RREADY,
    input  logic                  D_REQ,
    input  logic [ADDR_DEPTH+1:0] D_ADDR,
    output logic                  D_GNT,
    output logic                  D_RVALID,
    output logic [31:0]           D_RDATA,
    output logic                  D_RERR,
    input  logic                  D_RREADY,
    output logic                  MEM_RDEN,
    output logic [ADDR_DEPTH-1:0] MEM_ADDR,
    input  logic [31:0]           MEM_DATA
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE_WAIT = 2'd1,
        RESP       = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        prio_q, prio_d;
    logic        err_q, err_d;
    logic [31:0] hold_q, hold_d;

    logic                  win;
    logic                  mis;
    logic [ADDR_DEPTH+1:0] sel_addr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    // prio_q set means port 1 wins a tie
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        err_d    = err_q;
        hold_d   = hold_q;
        F_GNT    = 1'b0;
        D_GNT    = 1'b0;
        F_RVALID = 1'b0;
        F_RDATA  = '0;
        F_RERR   = 1'b0;
        D_RVALID = 1'b0;
        D_RDATA  = '0;
        D_RERR   = 1'b0;
        MEM_RDEN = 1'b0;
        MEM_ADDR = '0;
        win      = D_REQ && (!F_REQ || prio_q);
        sel_addr = win ? D_ADDR : F_ADDR;
        mis      = sel_addr[1:0] != 2'b00;

        unique case (state_q)
            IDLE: begin
                // grants are held off while reset is asserted
                if (RST_N && (F_REQ || D_REQ)) begin
                    F_GNT   = !win;
                    D_GNT   = win;
                    owner_d = win;
                    prio_d  = !win;
                    err_d   = mis;
                    if (!mis) begin
                        MEM_RDEN = 1'b1;
                        MEM_ADDR = sel_addr[ADDR_DEPTH+1:2];
                    end
                    state_d = ISSUE_WAIT;
                end
            end
            ISSUE_WAIT: begin
                hold_d  = err_q ? 32'd0 : MEM_DATA;
                state_d = RESP;
            end
            RESP: begin
                if (owner_q) begin
                    D_RVALID = 1'b1;
                    D_RDATA  = hold_q;
                    D_RERR   = err_q;
                    if (D_RREADY) state_d = IDLE;
                end else begin
                    F_RVALID = 1'b1;
                    F_RDATA  = hold_q;
                    F_RERR   = err_q;
                    if (F_RREADY) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
